// File: rtl/i2s_rx.sv
// I2S / left-justified serial audio receiver: synchronises bck/ws/din into clk,
// deserialises left/right words and presents them as a stereo pair with lock tracking.
module i2s_rx #(
  parameter int WIDTH   = 16,
  parameter int DELAY   = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i2s_bck,
  input  logic                    i2s_ws,
  input  logic                    i2s_din,
  output logic signed [WIDTH-1:0] left_out,
  output logic signed [WIDTH-1:0] right_out,
  output logic                    sample_valid,
  output logic                    locked,
  output logic                    sync_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {S_SEARCH, S_SKIP, S_SHIFT, S_HOLD} state_t;

  function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
    return (v == WD_MAX) ? v : v + WD_W'(1);
  endfunction

  logic r_bck_s1, r_bck_s2, r_bck_d;
  logic r_ws_s1, r_ws_s2, r_din_s1, r_din_s2;
  logic w_rise;

  logic r_vld_p0, r_ws_p0, r_din_p0;

  state_t r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WD_W-1:0]  r_wdog;
  logic r_chan, w_chan_nxt, r_ws_prev;
  logic w_shift, w_done, w_err, w_start, w_trans, w_fall, w_timeout;
  logic signed [WIDTH-1:0] r_shreg;
  logic r_vld_p1, r_chan_p1, r_err_p1, r_tmo_p1;

  logic signed [WIDTH-1:0] r_stage;
  logic r_stage_vld;

  assign w_rise    = r_bck_s2 & ~r_bck_d;
  assign w_timeout = (r_wdog == WD_MAX);

  // ---- stage p0: two-flop synchronisers and bck rise detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bck_s1 <= 1'b0;
      r_bck_s2 <= 1'b0;
      r_bck_d  <= 1'b0;
      r_ws_s1  <= 1'b0;
      r_ws_s2  <= 1'b0;
      r_din_s1 <= 1'b0;
      r_din_s2 <= 1'b0;
      r_vld_p0 <= 1'b0;
      r_ws_p0  <= 1'b0;
    end else begin
      r_bck_s1 <= i2s_bck;
      r_bck_s2 <= r_bck_s1;
      r_bck_d  <= r_bck_s2;
      r_ws_s1  <= i2s_ws;
      r_ws_s2  <= r_ws_s1;
      r_din_s1 <= i2s_din;
      r_din_s2 <= r_din_s1;
      r_vld_p0 <= w_rise;
      r_ws_p0  <= r_ws_s2;
    end
  end

  always_ff @(posedge clk) begin
    r_din_p0 <= r_din_s2;
  end

  // ---- stage p1: framing FSM, bit counter, shift register, watchdog
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_SEARCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_chan_nxt  = r_chan;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    w_start     = 1'b0;
    w_trans     = r_vld_p0 && (r_ws_p0 != r_ws_prev);
    w_fall      = w_trans && !r_ws_p0;
    if (w_timeout) begin
      w_state_nxt = S_SEARCH;
    end else if (r_vld_p0) begin
      unique case (r_state)
        S_SEARCH: w_start = w_fall;
        S_SKIP, S_SHIFT: begin
          if (w_trans) begin
            // Short word: a falling ws doubles as the next left-word start.
            w_err = 1'b1;
            if (w_fall) w_start = 1'b1;
            else        w_state_nxt = S_SEARCH;
          end else if (r_state == S_SKIP) begin
            // The ws-change bit was the skipped one; this bit is the MSB.
            w_shift     = 1'b1;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = S_SHIFT;
          end else begin
            w_shift = 1'b1;
            if (r_cnt == LAST_BIT) begin
              w_done      = 1'b1;
              w_state_nxt = S_HOLD;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        S_HOLD:   w_start = w_trans;
        default:  w_state_nxt = S_SEARCH;
      endcase
      if (w_start) begin
        w_chan_nxt = r_ws_p0;
        if (DELAY != 0) begin
          w_state_nxt = S_SKIP;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_SHIFT;
          w_shift     = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_chan    <= 1'b0;
      r_ws_prev <= 1'b0;
      r_wdog    <= '0;
      r_vld_p1  <= 1'b0;
      r_chan_p1 <= 1'b0;
      r_err_p1  <= 1'b0;
      r_tmo_p1  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_chan    <= w_chan_nxt;
      if (r_vld_p0) r_ws_prev <= r_ws_p0;
      r_wdog    <= w_rise ? '0 : sat_inc(r_wdog);
      r_vld_p1  <= w_done;
      r_chan_p1 <= r_chan;
      r_err_p1  <= w_err;
      r_tmo_p1  <= w_timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (w_shift) r_shreg <= {r_shreg[WIDTH-2:0], r_din_p0};
  end

  // ---- stage p2: left staging, paired output update, lock and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      left_out     <= '0;
      right_out    <= '0;
      r_stage      <= '0;
      r_stage_vld  <= 1'b0;
      sample_valid <= 1'b0;
      sync_err     <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      sync_err     <= r_err_p1;
      if (r_err_p1 || r_tmo_p1) begin
        locked      <= 1'b0;
        r_stage_vld <= 1'b0;
      end else if (r_vld_p1) begin
        if (!r_chan_p1) begin
          r_stage     <= r_shreg;
          r_stage_vld <= 1'b1;
        end else if (r_stage_vld) begin
          right_out    <= r_shreg;
          left_out     <= r_stage;
          sample_valid <= 1'b1;
          locked       <= 1'b1;
          r_stage_vld  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives serial frames, queues expected stereo pairs and compares
// them as sample_valid fires; covers errors, long words, timeout, reset and Philips mode.
module tb_i2s_rx;

  logic clk = 1'b0;
  logic reset, bck, ws, din;
  logic [15:0] l0, r0, l1, r1;
  logic sv0, lk0, se0, sv1, lk1, se1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rise = 0;
  int serr0 = 0;
  int serr1 = 0;
  bit mon0_en = 1'b1;
  bit mon1_en = 1'b0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_rx #(.WIDTH(16), .DELAY(0), .TIMEOUT(255)) dut0 (
    .clk(clk), .reset(reset), .i2s_bck(bck), .i2s_ws(ws), .i2s_din(din),
    .left_out(l0), .right_out(r0), .sample_valid(sv0), .locked(lk0), .sync_err(se0)
  );

  i2s_rx #(.WIDTH(16), .DELAY(1), .TIMEOUT(255)) dut1 (
    .clk(clk), .reset(reset), .i2s_bck(bck), .i2s_ws(ws), .i2s_din(din),
    .left_out(l1), .right_out(r1), .sample_valid(sv1), .locked(lk1), .sync_err(se1)
  );

  // scoreboard monitors
  always @(negedge clk) begin
    if (mon0_en && se0) serr0++;
    if (mon0_en && sv0) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL dut0_unexpected_valid: got L=%h R=%h, required no sample", l0, r0);
      end else begin
        e0 = q0.pop_front();
        total++;
        if ({l0, r0} !== e0) begin
          bad++;
          $display("FAIL dut0_sample: got L=%h R=%h, required L=%h R=%h", l0, r0, e0[31:16], e0[15:0]);
        end
        total++;
        if (cyc - last_rise !== 4) begin
          bad++;
          $display("FAIL dut0_latency: got %0d clk, required 4", cyc - last_rise);
        end
        total++;
        if (lk0 !== 1'b1) begin
          bad++;
          $display("FAIL dut0_locked_with_valid: got %b, required 1", lk0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon1_en && se1) serr1++;
    if (mon1_en && sv1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL dut1_unexpected_valid: got L=%h R=%h, required no sample", l1, r1);
      end else begin
        e1 = q1.pop_front();
        total++;
        if ({l1, r1} !== e1) begin
          bad++;
          $display("FAIL dut1_sample: got L=%h R=%h, required L=%h R=%h", l1, r1, e1[31:16], e1[15:0]);
        end
        total++;
        if (cyc - last_rise !== 4) begin
          bad++;
          $display("FAIL dut1_latency: got %0d clk, required 4", cyc - last_rise);
        end
      end
    end
  end

  task automatic send_bit(input logic w, input logic d);
    @(negedge clk);
    bck = 1'b0; ws = w; din = d;
    repeat (18) @(negedge clk);
    bck = 1'b1;
    last_rise = cyc + 1;
    repeat (17) @(negedge clk);
  endtask

  task automatic send_word(input logic w, input logic [31:0] data, input int nslots, input int dly);
    for (int s = 0; s < nslots; s++) begin
      int idx;
      logic b;
      idx = s - dly;
      b = (idx >= 0 && idx < 32) ? data[31-idx] : 1'b0;
      send_bit(w, b);
    end
  endtask

  task automatic send_frame(input logic [15:0] lv, input logic [15:0] rv);
    q0.push_back({lv, rv});
    send_word(1'b0, {lv, 16'h0}, 16, 0);
    send_word(1'b1, {rv, 16'h0}, 16, 0);
  endtask

  task automatic wait_q0(output bit ok);
    int n;
    n = 0;
    while (q0.size() != 0 && n < 400) begin @(negedge clk); n++; end
    ok = (q0.size() == 0);
  endtask

  task automatic wait_q1(output bit ok);
    int n;
    n = 0;
    while (q1.size() != 0 && n < 400) begin @(negedge clk); n++; end
    ok = (q1.size() == 0);
  endtask

  task automatic test_reset();
    reset = 1'b1; bck = 1'b0; ws = 1'b1; din = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (l0 !== 16'h0)  begin bad++; $display("FAIL rst_left0: got %h, required 0000", l0); end
    total++; if (r0 !== 16'h0)  begin bad++; $display("FAIL rst_right0: got %h, required 0000", r0); end
    total++; if (sv0 !== 1'b0)  begin bad++; $display("FAIL rst_valid0: got %b, required 0", sv0); end
    total++; if (lk0 !== 1'b0)  begin bad++; $display("FAIL rst_locked0: got %b, required 0", lk0); end
    total++; if (se0 !== 1'b0)  begin bad++; $display("FAIL rst_syncerr0: got %b, required 0", se0); end
    total++; if ({l1, r1} !== 32'h0) begin bad++; $display("FAIL rst_out1: got %h, required 0", {l1, r1}); end
    total++; if ({sv1, lk1, se1} !== 3'b0) begin bad++; $display("FAIL rst_flags1: got %b, required 000", {sv1, lk1, se1}); end
    reset = 1'b0;
  endtask

  task automatic test_normal();
    bit ok;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    total++; if (lk0 !== 1'b0) begin bad++; $display("FAIL normal_prelock: got %b, required 0", lk0); end
    for (int f = 0; f < 3; f++) send_frame(16'h1234, 16'hABCD);
    wait_q0(ok);
    total++; if (!ok) begin bad++; $display("FAIL normal_drain: pending=%0d, required 0", q0.size()); end
    repeat (30) @(negedge clk);
    total++; if ({l0, r0} !== 32'h1234ABCD) begin bad++; $display("FAIL normal_hold: got %h, required 1234abcd", {l0, r0}); end
    total++; if (lk0 !== 1'b1) begin bad++; $display("FAIL normal_locked: got %b, required 1", lk0); end
    total++; if (serr0 !== 0) begin bad++; $display("FAIL normal_syncerr: got %0d, required 0", serr0); end
  endtask

  task automatic test_short_word();
    bit ok;
    int base;
    base = serr0;
    send_word(1'b0, 32'hFFC0_0000, 10, 0);
    send_word(1'b1, {16'h5555, 16'h0}, 16, 0);
    total++; if (serr0 !== base + 1) begin bad++; $display("FAIL short_syncerr: got %0d, required %0d", serr0, base + 1); end
    total++; if (lk0 !== 1'b0) begin bad++; $display("FAIL short_unlocked: got %b, required 0", lk0); end
    send_frame(16'h0F0F, 16'hF0F0);
    wait_q0(ok);
    total++; if (!ok) begin bad++; $display("FAIL short_drain: pending=%0d, required 0", q0.size()); end
    total++; if (lk0 !== 1'b1) begin bad++; $display("FAIL short_relock: got %b, required 1", lk0); end
  endtask

  task automatic test_long_word();
    bit ok;
    int base;
    base = serr0;
    q0.push_back({16'h8001, 16'h5AA5});
    send_word(1'b0, {16'h8001, 8'hFF, 8'h00}, 24, 0);
    send_word(1'b1, {16'h5AA5, 8'hFF, 8'h00}, 24, 0);
    wait_q0(ok);
    total++; if (!ok) begin bad++; $display("FAIL long_drain: pending=%0d, required 0", q0.size()); end
    total++; if (l0 !== 16'h8001) begin bad++; $display("FAIL long_left: got %h, required 8001", l0); end
    total++; if (serr0 !== base) begin bad++; $display("FAIL long_syncerr: got %0d, required %0d", serr0, base); end
  endtask

  task automatic test_timeout();
    bit ok;
    int base;
    base = serr0;
    send_frame(16'h1111, 16'h2222);
    wait_q0(ok);
    total++; if (!ok) begin bad++; $display("FAIL tmo_drain: pending=%0d, required 0", q0.size()); end
    @(negedge clk);
    bck = 1'b0;
    repeat (180) @(negedge clk);
    total++; if (lk0 !== 1'b1) begin bad++; $display("FAIL tmo_early: got %b, required 1", lk0); end
    repeat (120) @(negedge clk);
    total++; if (lk0 !== 1'b0) begin bad++; $display("FAIL tmo_unlock: got %b, required 0", lk0); end
    total++; if (serr0 !== base) begin bad++; $display("FAIL tmo_syncerr: got %0d, required %0d", serr0, base); end
    total++; if ({l0, r0} !== 32'h11112222) begin bad++; $display("FAIL tmo_retain: got %h, required 11112222", {l0, r0}); end
    send_frame(16'h3333, 16'h4444);
    wait_q0(ok);
    total++; if (!ok) begin bad++; $display("FAIL tmo_relock_drain: pending=%0d, required 0", q0.size()); end
    total++; if (lk0 !== 1'b1) begin bad++; $display("FAIL tmo_relock: got %b, required 1", lk0); end
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    send_frame(16'h6666, 16'h7777);
    wait_q0(ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_drain: pending=%0d, required 0", q0.size()); end
    send_word(1'b0, {16'h9999, 16'h0}, 16, 0);
    send_word(1'b1, {16'hC3C3, 16'h0}, 8, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if ({l0, r0} !== 32'h0) begin bad++; $display("FAIL rmid_outputs: got %h, required 0", {l0, r0}); end
    total++; if ({sv0, lk0, se0} !== 3'b0) begin bad++; $display("FAIL rmid_flags: got %b, required 000", {sv0, lk0, se0}); end
    reset = 1'b0;
    send_word(1'b1, 32'h0, 8, 0);
    total++; if (lk0 !== 1'b0) begin bad++; $display("FAIL rmid_nolock: got %b, required 0", lk0); end
    send_frame(16'hA5A5, 16'h5A5A);
    wait_q0(ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_next_drain: pending=%0d, required 0", q0.size()); end
    total++; if (lk0 !== 1'b1) begin bad++; $display("FAIL rmid_relock: got %b, required 1", lk0); end
  endtask

  task automatic test_delay1();
    bit ok;
    mon0_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mon1_en = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    q1.push_back({16'h7FFF, 16'h8000});
    send_word(1'b0, {16'h7FFF, 16'h0}, 32, 1);
    send_word(1'b1, {16'h8000, 16'h0}, 32, 1);
    wait_q1(ok);
    total++; if (!ok) begin bad++; $display("FAIL d1_drain: pending=%0d, required 0", q1.size()); end
    total++; if (l1 !== 16'h7FFF) begin bad++; $display("FAIL d1_left: got %h, required 7fff", l1); end
    total++; if (r1 !== 16'h8000) begin bad++; $display("FAIL d1_right: got %h, required 8000", r1); end
    total++; if (lk1 !== 1'b1) begin bad++; $display("FAIL d1_locked: got %b, required 1", lk1); end
    total++; if (serr1 !== 0) begin bad++; $display("FAIL d1_syncerr: got %0d, required 0", serr1); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_short_word();
    test_long_word();
    test_timeout();
    test_reset_mid_word();
    test_delay1();
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
